// File: rtl/codec_stream_bridge_pkg.sv
// Shared constants, frame-width helper and underflow-policy type for the
// codec stream bridge.
package codec_pkg;

  localparam int NUM_CH = 2;
  localparam int DW_DEF = 16;
  localparam int FW_DEF = NUM_CH * DW_DEF;

  // Frame carries one sample per channel, left in the upper half.
  function automatic int frame_width(input int dw);
    return NUM_CH * dw;
  endfunction

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // What the DAC sees when its FIFO runs dry on a sample tick.
  typedef enum logic {
    UF_ZERO = 1'b0,
    UF_HOLD = 1'b1
  } uf_policy_e;

endpackage

// File: rtl/codec_stream_bridge_if.sv
// Bus bundle between the codec data-access controller / host and the bridge.
interface codec_stream_bridge_if #(
  parameter int FW = 32,
  parameter int AW = 3
);
  import codec_pkg::*;

  // Codec side
  logic             sample_tick;
  logic [FW-1:0]    adc_frame;
  logic [FW-1:0]    dac_frame;
  // Host side, ADC path
  logic             rd_adc_fifo;
  logic [FW-1:0]    adc_fifo_out;
  logic             adc_fifo_empty;
  logic [AW:0]      adc_fifo_level;
  // Host side, DAC path
  logic             wr_dac_fifo;
  logic [FW-1:0]    dac_fifo_in;
  logic             dac_fifo_full;
  logic [AW:0]      dac_fifo_level;
  // Mode and status
  logic             loopback;
  logic             mute;
  logic             clr_status;
  logic [CNT_W-1:0] adc_ovf_cnt;
  logic [CNT_W-1:0] dac_unf_cnt;
  logic             host_err;

  modport slave (
    input  sample_tick, adc_frame, rd_adc_fifo, wr_dac_fifo, dac_fifo_in,
           loopback, mute, clr_status,
    output dac_frame, adc_fifo_out, adc_fifo_empty, adc_fifo_level,
           dac_fifo_full, dac_fifo_level, adc_ovf_cnt, dac_unf_cnt, host_err
  );

  modport master (
    output sample_tick, adc_frame, rd_adc_fifo, wr_dac_fifo, dac_fifo_in,
           loopback, mute, clr_status,
    input  dac_frame, adc_fifo_out, adc_fifo_empty, adc_fifo_level,
           dac_fifo_full, dac_fifo_level, adc_ovf_cnt, dac_unf_cnt, host_err
  );

endinterface

// File: rtl/codec_stream_bridge_fifo.sv
// First-word-fall-through synchronous FIFO. A write into a full FIFO is
// accepted only when a real pop happens in the same cycle; reads on empty
// are ignored. Head reads as zero while empty.
module sync_fifo_fwft #(
  parameter int FW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [FW-1:0] w_data,
  input  logic          rd,
  output logic [FW-1:0] r_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [FW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_wr, do_rd;

  // Extra wrap bit distinguishes full from empty when addresses match.
  assign level  = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd  = rd & ~empty;
  assign do_wr  = wr & (~full | do_rd);
  assign r_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + (AW+1)'(1);
    if (do_rd) rptr_d = rptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is data only and needs no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= w_data;
  end

endmodule

// File: rtl/codec_stream_bridge.sv
// Stereo sample-buffering bridge: ADC frames are queued for the host, host
// frames are queued for the DAC, one frame each way per sample tick.
// Provides occupancy, overflow/underflow counters, mute, loopback and a
// selectable underflow policy.
module codec_stream_bridge #(
  parameter int DW      = codec_pkg::DW_DEF,
  parameter int AW      = 3,
  parameter bit UF_HOLD = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  codec_stream_bridge_if.slave bus
);
  import codec_pkg::*;

  localparam int         FW        = frame_width(DW);
  localparam uf_policy_e UF_POLICY = uf_policy_e'(UF_HOLD);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [FW-1:0]    adc_head, dac_head;
  logic             adc_empty, adc_full, dac_empty, dac_full;
  logic [AW:0]      adc_level, dac_level;

  logic             adc_pop, adc_ovf_ev;
  logic             dac_tick, dac_pop, dac_unf_ev, host_err_ev;

  logic [FW-1:0]    src_frame;
  logic [FW-1:0]    dac_frame_q, dac_frame_d;
  logic [FW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] adc_ovf_q, adc_ovf_d;
  logic [CNT_W-1:0] dac_unf_q, dac_unf_d;
  logic             host_err_q, host_err_d;

  sync_fifo_fwft #(.FW(FW), .AW(AW)) u_adc_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.sample_tick),
    .w_data (bus.adc_frame),
    .rd     (bus.rd_adc_fifo),
    .r_data (adc_head),
    .empty  (adc_empty),
    .full   (adc_full),
    .level  (adc_level)
  );

  // In loopback the DAC FIFO is left alone, so its pop request is masked.
  sync_fifo_fwft #(.FW(FW), .AW(AW)) u_dac_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.wr_dac_fifo),
    .w_data (bus.dac_fifo_in),
    .rd     (dac_tick),
    .r_data (dac_head),
    .empty  (dac_empty),
    .full   (dac_full),
    .level  (dac_level)
  );

  // Event decode; a tick into a full ADC FIFO is rescued by a same-cycle pop,
  // and a host push into a full DAC FIFO is rescued by a same-cycle tick pop.
  assign adc_pop     = bus.rd_adc_fifo & ~adc_empty;
  assign adc_ovf_ev  = bus.sample_tick & adc_full & ~adc_pop;
  assign dac_tick    = bus.sample_tick & ~bus.loopback;
  assign dac_pop     = dac_tick & ~dac_empty;
  assign dac_unf_ev  = dac_tick & dac_empty;
  assign host_err_ev = (bus.rd_adc_fifo & adc_empty) |
                       (bus.wr_dac_fifo & dac_full & ~dac_pop);

  // DAC frame selection; updates only on a tick. The hold register tracks the
  // last frame sent unmuted so a dry FIFO can repeat it.
  always_comb begin
    src_frame = '0;
    if (bus.loopback)                src_frame = bus.adc_frame;
    else if (!dac_empty)             src_frame = dac_head;
    else if (UF_POLICY == UF_ZERO)   src_frame = '0;
    else                             src_frame = hold_q;

    dac_frame_d = dac_frame_q;
    hold_d      = hold_q;
    if (bus.sample_tick) begin
      dac_frame_d = bus.mute ? '0 : src_frame;
      if (!bus.mute) hold_d = src_frame;
    end
  end

  // Status next-state; clearing overrides any same-cycle event.
  always_comb begin
    adc_ovf_d  = adc_ovf_q;
    dac_unf_d  = dac_unf_q;
    host_err_d = host_err_q;
    if (adc_ovf_ev)  adc_ovf_d  = sat_inc(adc_ovf_q);
    if (dac_unf_ev)  dac_unf_d  = sat_inc(dac_unf_q);
    if (host_err_ev) host_err_d = 1'b1;
    if (bus.clr_status) begin
      adc_ovf_d  = '0;
      dac_unf_d  = '0;
      host_err_d = 1'b0;
    end
  end

  // Output frame, hold frame and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_frame_q <= '0;
      hold_q      <= '0;
      adc_ovf_q   <= '0;
      dac_unf_q   <= '0;
      host_err_q  <= 1'b0;
    end else begin
      dac_frame_q <= dac_frame_d;
      hold_q      <= hold_d;
      adc_ovf_q   <= adc_ovf_d;
      dac_unf_q   <= dac_unf_d;
      host_err_q  <= host_err_d;
    end
  end

  assign bus.dac_frame      = dac_frame_q;
  assign bus.adc_fifo_out   = adc_head;
  assign bus.adc_fifo_empty = adc_empty;
  assign bus.adc_fifo_level = adc_level;
  assign bus.dac_fifo_full  = dac_full;
  assign bus.dac_fifo_level = dac_level;
  assign bus.adc_ovf_cnt    = adc_ovf_q;
  assign bus.dac_unf_cnt    = dac_unf_q;
  assign bus.host_err       = host_err_q;

endmodule

// File: tb/tb_codec_stream_bridge.sv
// Bench for codec_stream_bridge: one instance per underflow policy, driven
// identically and compared against a queue-based behavioural model.
module tb_codec_stream_bridge;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int FW    = 2 * DW;
  localparam int DEPTH = 1 << AW;
  localparam int SAT   = 65535;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          tick  = 1'b0;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic          lb    = 1'b0;
  logic          mute  = 1'b0;
  logic          clr   = 1'b0;
  logic [FW-1:0] adc   = '0;
  logic [FW-1:0] din   = '0;

  always #5 clk = ~clk;

  codec_stream_bridge_if #(.FW(FW), .AW(AW)) bus_h ();
  codec_stream_bridge_if #(.FW(FW), .AW(AW)) bus_z ();

  assign bus_h.sample_tick = tick;  assign bus_z.sample_tick = tick;
  assign bus_h.adc_frame   = adc;   assign bus_z.adc_frame   = adc;
  assign bus_h.rd_adc_fifo = rd;    assign bus_z.rd_adc_fifo = rd;
  assign bus_h.wr_dac_fifo = wr;    assign bus_z.wr_dac_fifo = wr;
  assign bus_h.dac_fifo_in = din;   assign bus_z.dac_fifo_in = din;
  assign bus_h.loopback    = lb;    assign bus_z.loopback    = lb;
  assign bus_h.mute        = mute;  assign bus_z.mute        = mute;
  assign bus_h.clr_status  = clr;   assign bus_z.clr_status  = clr;

  codec_stream_bridge #(.DW(DW), .AW(AW), .UF_HOLD(1'b1)) dut_h (
    .clk(clk), .reset(reset), .bus(bus_h)
  );
  codec_stream_bridge #(.DW(DW), .AW(AW), .UF_HOLD(1'b0)) dut_z (
    .clk(clk), .reset(reset), .bus(bus_z)
  );

  // Behavioural model state
  logic [FW-1:0] aq[$];
  logic [FW-1:0] dq[$];
  int            m_ovf, m_unf;
  bit            m_err;
  logic [FW-1:0] m_frm_h, m_frm_z, m_last;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    dq.delete();
    m_ovf = 0; m_unf = 0; m_err = 0;
    m_frm_h = '0; m_frm_z = '0; m_last = '0;
  endtask

  // One clock of the model, from the inputs currently applied.
  task automatic model_step();
    bit            popped;
    logic [FW-1:0] head, src_h, src_z;
    popped = 0; head = '0; src_h = '0; src_z = '0;
    if (rd) begin
      if (aq.size() > 0) void'(aq.pop_front());
      else m_err = 1;
    end
    if (tick) begin
      if (aq.size() < DEPTH) aq.push_back(adc);
      else if (m_ovf < SAT) m_ovf++;
    end
    if (tick && !lb) begin
      if (dq.size() > 0) begin head = dq.pop_front(); popped = 1; end
      else if (m_unf < SAT) m_unf++;
    end
    if (wr) begin
      if (dq.size() < DEPTH) dq.push_back(din);
      else m_err = 1;
    end
    if (tick) begin
      if (lb)          begin src_h = adc;    src_z = adc;  end
      else if (popped) begin src_h = head;   src_z = head; end
      else             begin src_h = m_last; src_z = '0;   end
      m_frm_h = mute ? '0 : src_h;
      m_frm_z = mute ? '0 : src_z;
      if (!mute) m_last = src_h;
    end
    if (clr) begin m_ovf = 0; m_unf = 0; m_err = 0; end
  endtask

  task automatic check_all();
    chk("adc_out",   bus_h.adc_fifo_out, (aq.size() > 0) ? aq[0] : 32'h0);
    chk("adc_empty", 32'(bus_h.adc_fifo_empty), 32'(aq.size() == 0));
    chk("adc_level", 32'(bus_h.adc_fifo_level), 32'(aq.size()));
    chk("dac_full",  32'(bus_h.dac_fifo_full), 32'(dq.size() == DEPTH));
    chk("dac_level", 32'(bus_h.dac_fifo_level), 32'(dq.size()));
    chk("dac_frame_hold", bus_h.dac_frame, m_frm_h);
    chk("dac_frame_zero", bus_z.dac_frame, m_frm_z);
    chk("adc_ovf",   32'(bus_h.adc_ovf_cnt), 32'(m_ovf));
    chk("dac_unf",   32'(bus_h.dac_unf_cnt), 32'(m_unf));
    chk("dac_unf_z", 32'(bus_z.dac_unf_cnt), 32'(m_unf));
    chk("host_err",  32'(bus_h.host_err), 32'(m_err));
  endtask

  task automatic cycle(input bit do_chk);
    model_step();
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle_inputs();
    tick = 0; rd = 0; wr = 0; lb = 0; mute = 0; clr = 0;
  endtask

  initial begin
    logic [FW-1:0] first_push;
    int            unf_save;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();

    // ADC fill, overflow, ordered drain
    for (int i = 1; i <= DEPTH; i++) begin
      tick = 1; adc = {16'(i), 16'(i)};
      cycle(1);
    end
    chk("t1_level8", 32'(bus_h.adc_fifo_level), 32'd8);
    chk("t1_ovf0",   32'(bus_h.adc_ovf_cnt), 32'd0);
    adc = 32'h0009_0009;
    cycle(1);
    chk("t1_ovf1",   32'(bus_h.adc_ovf_cnt), 32'd1);
    tick = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("t1_head", bus_h.adc_fifo_out, {16'(i), 16'(i)});
      rd = 1;
      cycle(1);
    end
    rd = 0;
    chk("t1_empty", 32'(bus_h.adc_fifo_empty), 32'd1);

    // DAC playout and underflow policy
    clr = 1; cycle(1); clr = 0;
    wr = 1; din = 32'hAAAA_5555; cycle(1);
    din = 32'h1234_5678; cycle(1);
    wr = 0; tick = 1;
    cycle(1);
    chk("t2_f1_hold", bus_h.dac_frame, 32'hAAAA_5555);
    chk("t2_f1_zero", bus_z.dac_frame, 32'hAAAA_5555);
    cycle(1);
    chk("t2_f2_hold", bus_h.dac_frame, 32'h1234_5678);
    cycle(1);
    chk("t2_uf_hold", bus_h.dac_frame, 32'h1234_5678);
    chk("t2_uf_zero", bus_z.dac_frame, 32'h0);
    chk("t2_unf1",    32'(bus_h.dac_unf_cnt), 32'd1);
    tick = 0;

    // DAC full with simultaneous push and tick pop
    clr = 1; cycle(1); clr = 0;
    first_push = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr = 1; din = $urandom;
      if (i == 0) first_push = din;
      cycle(1);
    end
    chk("t3_full", 32'(bus_h.dac_fifo_full), 32'd1);
    wr = 1; tick = 1; din = 32'hCAFE_D00D;
    cycle(1);
    wr = 0;
    chk("t3_level8", 32'(bus_h.dac_fifo_level), 32'd8);
    chk("t3_noerr",  32'(bus_h.host_err), 32'd0);
    chk("t3_first",  bus_h.dac_frame, first_push);
    repeat (DEPTH) cycle(1);
    chk("t3_last",   bus_h.dac_frame, 32'hCAFE_D00D);

    // Loopback and mute
    unf_save = m_unf;
    lb = 1; adc = 32'hBEEF_CAFE; tick = 1;
    cycle(1);
    chk("t4_lb_hold", bus_h.dac_frame, 32'hBEEF_CAFE);
    chk("t4_lb_zero", bus_z.dac_frame, 32'hBEEF_CAFE);
    chk("t4_unf",     32'(bus_h.dac_unf_cnt), 32'(unf_save));
    mute = 1;
    cycle(1);
    chk("t4_mute", bus_h.dac_frame, 32'h0);
    idle_inputs();

    // Host error and clear priority
    for (int i = 0; i < DEPTH && aq.size() > 0; i++) begin
      rd = 1; cycle(1);
    end
    rd = 0;
    chk("t5_adc_empty", 32'(bus_h.adc_fifo_empty), 32'd1);
    chk("t5_dac_empty", 32'(bus_h.dac_fifo_level), 32'd0);
    rd = 1; cycle(1); rd = 0;
    chk("t5_err", 32'(bus_h.host_err), 32'd1);
    clr = 1; tick = 1;
    cycle(1);
    idle_inputs();
    chk("t5_clr_unf", 32'(bus_h.dac_unf_cnt), 32'd0);
    chk("t5_clr_ovf", 32'(bus_h.adc_ovf_cnt), 32'd0);
    chk("t5_clr_err", 32'(bus_h.host_err), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      tick = ($urandom_range(0, 99) < 40);
      rd   = ($urandom_range(0, 99) < 30);
      wr   = ($urandom_range(0, 99) < 35);
      lb   = ($urandom_range(0, 99) < 15);
      mute = ($urandom_range(0, 99) < 15);
      clr  = ($urandom_range(0, 99) < 3);
      adc  = $urandom;
      din  = $urandom;
      cycle(1);
    end
    idle_inputs();

    // Counter saturation, then asynchronous reset mid-stream
    clr = 1; cycle(1); clr = 0;
    tick = 1;
    for (int i = 0; i < SAT + DEPTH + 4; i++) begin
      adc = $urandom;
      cycle(0);
    end
    check_all();
    chk("t6_ovf_sat", 32'(bus_h.adc_ovf_cnt), 32'hFFFF);
    chk("t6_unf_sat", 32'(bus_h.dac_unf_cnt), 32'hFFFF);
    wr = 1; din = 32'h5A5A_A5A5;
    cycle(1);
    chk("t6_still_sat", 32'(bus_h.adc_ovf_cnt), 32'hFFFF);
    #2 reset = 1'b1;
    #1;
    idle_inputs();
    model_reset();
    chk("rst_adc_level", 32'(bus_h.adc_fifo_level), 32'd0);
    chk("rst_adc_empty", 32'(bus_h.adc_fifo_empty), 32'd1);
    chk("rst_adc_out",   bus_h.adc_fifo_out, 32'h0);
    chk("rst_dac_level", 32'(bus_h.dac_fifo_level), 32'd0);
    chk("rst_dac_full",  32'(bus_h.dac_fifo_full), 32'd0);
    chk("rst_dac_frame", bus_h.dac_frame, 32'h0);
    chk("rst_ovf",       32'(bus_h.adc_ovf_cnt), 32'd0);
    chk("rst_unf",       32'(bus_h.dac_unf_cnt), 32'd0);
    chk("rst_err",       32'(bus_h.host_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check_all();
    for (int i = 0; i < 40; i++) begin
      tick = $urandom_range(0, 1);
      wr   = $urandom_range(0, 1);
      rd   = $urandom_range(0, 1);
      adc  = $urandom;
      din  = $urandom;
      cycle(1);
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
